// File: rtl/vga_pkg.sv
// Shared types for the VGA display controller: mode encoding, pipeline payload
// carried alongside each pixel slot, and the colour-bar table.
package vga_pkg;

  typedef enum logic [1:0] {MODE_EXT, MODE_BARS, MODE_CHECK, MODE_SOLID} mode_t;

  localparam int unsigned NUM_BARS  = 8;
  localparam int unsigned BAR_IDX_W = 4;

  // Per-slot flags that travel with a pixel from the counter stage to the pins
  typedef struct packed {
    logic                 hs;
    logic                 vs;
    logic                 vis;
    logic                 frame_start;
    logic                 line_start;
    logic                 chk_x;
    logic                 chk_y;
    logic [BAR_IDX_W-1:0] bar_idx;
  } pipe_t;

  localparam int unsigned PIPE_W = $bits(pipe_t);

  // Bar colours as {R,G,B} on/off; any index past the last bar is black
  function automatic logic [2:0] bar_rgb(input logic [BAR_IDX_W-1:0] idx);
    case (idx)
      BAR_IDX_W'(0): bar_rgb = 3'b111;
      BAR_IDX_W'(1): bar_rgb = 3'b110;
      BAR_IDX_W'(2): bar_rgb = 3'b011;
      BAR_IDX_W'(3): bar_rgb = 3'b010;
      BAR_IDX_W'(4): bar_rgb = 3'b101;
      BAR_IDX_W'(5): bar_rgb = 3'b100;
      BAR_IDX_W'(6): bar_rgb = 3'b001;
      default:       bar_rgb = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with async reset value and synchronous flush.
module vga_delay_line #(
  parameter int unsigned     WIDTH     = 1,
  parameter int unsigned     DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RESET_VAL;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_display_ctrl.sv
// VGA timing generator with fixed-latency pixel fetch, built-in test patterns
// and registered DAC outputs aligned PIX_LAT+1 cycles behind the counters.
module vga_display_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned COLOR_W   = 8,
  parameter int unsigned PIX_LAT   = 2,
  parameter int unsigned CHK_SHIFT = 5
) (
  input  logic                           vga_clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [1:0]                     mode,
  input  logic [3*COLOR_W-1:0]           solid_rgb,
  output logic                           req_valid,
  output logic [$clog2(H_VISIBLE)-1:0]   req_x,
  output logic [$clog2(V_VISIBLE)-1:0]   req_y,
  input  logic                           pix_valid,
  input  logic [3*COLOR_W-1:0]           pix_rgb,
  input  logic                           underrun_clr,
  output logic                           underrun,
  output logic                           frame_start,
  output logic                           line_start,
  output logic [COLOR_W-1:0]             VGA_R,
  output logic [COLOR_W-1:0]             VGA_G,
  output logic [COLOR_W-1:0]             VGA_B,
  output logic                           VGA_HS,
  output logic                           VGA_VS,
  output logic                           VGA_BLANK_N,
  output logic                           VGA_SYNC_N
);

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HC_W         = $clog2(H_TOTAL);
  localparam int unsigned VC_W         = $clog2(V_TOTAL);
  localparam int unsigned X_W          = $clog2(H_VISIBLE);
  localparam int unsigned Y_W          = $clog2(V_VISIBLE);
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned BAR_W        = H_VISIBLE >> 3;
  localparam int unsigned BP_W         = $clog2(BAR_W + 1);
  localparam int unsigned RGB_W        = 3 * COLOR_W;

  logic [HC_W-1:0]      hc;
  logic [VC_W-1:0]      vc;
  logic [BP_W-1:0]      bar_pos;
  logic [BAR_IDX_W-1:0] bar_idx;
  mode_t                active_mode;
  mode_t                mode_s0;
  logic                 at_origin;
  logic                 vis_s0;
  pipe_t                s0;
  pipe_t                d_q;
  logic [RGB_W-1:0]     rgb_c;
  logic                 under_c;
  logic [2:0]           bar3;

  // Raster counters; en low parks them at the origin
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (!en) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == HC_W'(H_TOTAL - 1)) begin
      hc <= '0;
      vc <= (vc == VC_W'(V_TOTAL - 1)) ? '0 : vc + VC_W'(1);
    end else begin
      hc <= hc + HC_W'(1);
    end
  end

  // Bar counter tracks hc so the bar index needs no divider; saturates past the last bar
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (!en || hc == HC_W'(H_TOTAL - 1)) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (bar_idx != BAR_IDX_W'(NUM_BARS)) begin
      if (bar_pos == BP_W'(BAR_W - 1)) begin
        bar_pos <= '0;
        bar_idx <= bar_idx + BAR_IDX_W'(1);
      end else begin
        bar_pos <= bar_pos + BP_W'(1);
      end
    end
  end

  assign at_origin = en && (hc == '0) && (vc == '0);
  // The origin slot already uses the newly sampled mode so a frame is never split
  assign mode_s0   = at_origin ? mode_t'(mode) : active_mode;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n)         active_mode <= MODE_EXT;
    else if (at_origin) active_mode <= mode_t'(mode);
  end

  assign vis_s0    = en && (hc < HC_W'(H_VISIBLE)) && (vc < VC_W'(V_VISIBLE));
  assign req_valid = rst_n && vis_s0 && (mode_s0 == MODE_EXT);
  assign req_x     = X_W'(hc);
  assign req_y     = Y_W'(vc);

  always_comb begin
    s0             = '0;
    s0.hs          = en && (hc >= HC_W'(H_SYNC_START)) && (hc < HC_W'(H_SYNC_END));
    s0.vs          = en && (vc >= VC_W'(V_SYNC_START)) && (vc < VC_W'(V_SYNC_END));
    s0.vis         = vis_s0;
    s0.frame_start = at_origin;
    s0.line_start  = en && (hc == '0);
    s0.chk_x       = hc[CHK_SHIFT];
    s0.chk_y       = vc[CHK_SHIFT];
    s0.bar_idx     = bar_idx;
  end

  vga_delay_line #(
    .WIDTH     (PIPE_W),
    .DEPTH     (PIX_LAT),
    .RESET_VAL (PIPE_W'(0))
  ) u_delay (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .flush   (~en),
    .d       (s0),
    .q       (d_q)
  );

  // Colour select for the slot whose fetched pixel is arriving this cycle
  always_comb begin
    rgb_c   = '0;
    under_c = 1'b0;
    bar3    = bar_rgb(d_q.bar_idx);
    if (d_q.vis) begin
      case (active_mode)
        MODE_EXT: begin
          if (pix_valid) rgb_c = pix_rgb;
          else           under_c = 1'b1;
        end
        MODE_BARS:  rgb_c = {{COLOR_W{bar3[2]}}, {COLOR_W{bar3[1]}}, {COLOR_W{bar3[0]}}};
        MODE_CHECK: rgb_c = {RGB_W{d_q.chk_x ^ d_q.chk_y}};
        default:    rgb_c = solid_rgb;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n || !en) begin
      if (!rst_n || !en) begin
        VGA_R       <= '0;
        VGA_G       <= '0;
        VGA_B       <= '0;
        VGA_BLANK_N <= 1'b0;
        VGA_HS      <= ~HS_POL;
        VGA_VS      <= ~VS_POL;
        frame_start <= 1'b0;
        line_start  <= 1'b0;
      end
    end else begin
      {VGA_R, VGA_G, VGA_B} <= rgb_c;
      VGA_BLANK_N <= d_q.vis;
      VGA_HS      <= d_q.hs ? HS_POL : ~HS_POL;
      VGA_VS      <= d_q.vs ? VS_POL : ~VS_POL;
      frame_start <= d_q.frame_start;
      line_start  <= d_q.line_start;
    end
  end

  // Sticky underrun; a new underrun outranks a simultaneous clear
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n)               underrun <= 1'b0;
    else if (en && under_c)   underrun <= 1'b1;
    else if (underrun_clr)    underrun <= 1'b0;
  end

  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Directed bench for vga_display_ctrl on a reduced 66x48 raster with a
// fixed-latency pixel source model.
module tb_vga_display_ctrl;

  localparam int H_VIS = 66, H_FP = 4, H_SW = 8, H_BP = 6;
  localparam int V_VIS = 48, V_FP = 2, V_SW = 2, V_BP = 3;
  localparam int H_T   = H_VIS + H_FP + H_SW + H_BP;   // 84
  localparam int V_T   = V_VIS + V_FP + V_SW + V_BP;   // 55
  localparam int FRAME = H_T * V_T;                    // 4620
  localparam int LAT   = 3;

  logic        vga_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd3;
  logic [23:0] solid_rgb = 24'hFF0000;
  logic        req_valid;
  logic [6:0]  req_x;
  logic [5:0]  req_y;
  logic        pix_valid;
  logic [23:0] pix_rgb;
  logic        underrun_clr = 1'b0;
  logic        underrun, frame_start, line_start;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;
  logic drop_en = 1'b0;

  vga_display_ctrl #(
    .H_VISIBLE(H_VIS), .H_FRONT(H_FP), .H_SYNC(H_SW), .H_BACK(H_BP),
    .V_VISIBLE(V_VIS), .V_FRONT(V_FP), .V_SYNC(V_SW), .V_BACK(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .PIX_LAT(2), .CHK_SHIFT(5)
  ) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .pix_valid(pix_valid), .pix_rgb(pix_rgb),
    .underrun_clr(underrun_clr), .underrun(underrun),
    .frame_start(frame_start), .line_start(line_start),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n), .VGA_SYNC_N(vga_sync_n)
  );

  always #5 vga_clk = ~vga_clk;

  // Upstream source: answers each request two cycles later with {x,y,5A}
  logic        r1_v = 1'b0, r2_v = 1'b0, r1_ok = 1'b1, r2_ok = 1'b1;
  logic [23:0] r1_rgb = '0, r2_rgb = '0;
  always @(posedge vga_clk) begin
    r1_v   <= req_valid;
    r1_ok  <= !(drop_en && req_x == 7'd10 && req_y == 6'd10);
    r1_rgb <= {8'(req_x), 8'(req_y), 8'h5A};
    r2_v   <= r1_v;
    r2_ok  <= r1_ok;
    r2_rgb <= r1_rgb;
  end
  assign pix_valid = r2_v && r2_ok;
  assign pix_rgb   = r2_rgb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic goto(input int x, input int y);
    int target;
    target = y * H_T + x;
    while (pos < target) begin
      wait_cycle();
      pos++;
    end
  endtask

  task automatic sync_frame(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      wait_cycle();
      if (frame_start) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
    pos = 0;
  endtask

  task automatic en_rise_latency(input string tag);
    int cnt;
    cnt = 0;
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_cycle();
      cnt++;
      if (frame_start) break;
    end
    check(tag, 32'(cnt), 32'(LAT));
    pos = 0;
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, vga_r, vga_g, vga_b};
  endfunction

  initial begin
    int reqs;
    // Reset values
    #12;
    check("rst_blank", 32'(vga_blank_n), 32'd0);
    check("rst_hs", 32'(vga_hs), 32'd1);
    check("rst_vs", 32'(vga_vs), 32'd1);
    check("rst_rgb", rgb(), 32'h0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_req", 32'(req_valid), 32'd0);
    check("rst_under", 32'(underrun), 32'd0);
    check("sync_n", 32'(vga_sync_n), 32'd0);
    @(negedge vga_clk);
    rst_n = 1'b1;
    repeat (3) wait_cycle();
    check("idle_blank", 32'(vga_blank_n), 32'd0);
    check("idle_req", 32'(req_valid), 32'd0);

    // Frame A: solid red, sync timing, frame period
    @(negedge vga_clk);
    en_rise_latency("en_lat0");
    check("ls_at_origin", 32'(line_start), 32'd1);
    check("solid_00", rgb(), 32'hFF0000);
    check("blank_00", 32'(vga_blank_n), 32'd1);
    goto(1, 0);   check("ls_col1", 32'(line_start), 32'd0);
    goto(65, 0);  check("solid_65", rgb(), 32'hFF0000);
    goto(66, 0);  check("hblank_rgb", rgb(), 32'h0);
                  check("hblank_bn", 32'(vga_blank_n), 32'd0);
    goto(69, 0);  check("hs_69", 32'(vga_hs), 32'd1);
    goto(70, 0);  check("hs_70", 32'(vga_hs), 32'd0);
    goto(77, 0);  check("hs_77", 32'(vga_hs), 32'd0);
    goto(78, 0);  check("hs_78", 32'(vga_hs), 32'd1);
    goto(0, 20);  mode = 2'd1;
    goto(5, 30);  check("solid_after_switch", rgb(), 32'hFF0000);
    goto(0, 48);  check("vblank_rgb", rgb(), 32'h0);
    goto(0, 49);  check("vs_49", 32'(vga_vs), 32'd1);
    goto(0, 50);  check("vs_50", 32'(vga_vs), 32'd0);
    goto(40, 51); check("vs_51", 32'(vga_vs), 32'd0);
    goto(0, 52);  check("vs_52", 32'(vga_vs), 32'd1);
    goto(H_T - 1, V_T - 1); check("fs_before_period", 32'(frame_start), 32'd0);
    wait_cycle(); check("fs_period", 32'(frame_start), 32'd1);
    pos = 0;

    // Frame B: colour bars
    check("bar_white", rgb(), 32'hFFFFFF);
    goto(7, 0);   check("bar_white_end", rgb(), 32'hFFFFFF);
    goto(15, 0);  check("bar_yellow", rgb(), 32'hFFFF00);
    goto(16, 0);  check("bar_cyan", rgb(), 32'h00FFFF);
    goto(24, 0);  check("bar_green", rgb(), 32'h00FF00);
    goto(32, 0);  check("bar_magenta", rgb(), 32'hFF00FF);
    goto(40, 0);  check("bar_red", rgb(), 32'hFF0000);
    goto(55, 0);  check("bar_blue", rgb(), 32'h0000FF);
    goto(56, 0);  check("bar_black", rgb(), 32'h0);
    goto(65, 0);  check("bar_remainder", rgb(), 32'h0);
                  check("bar_rem_bn", 32'(vga_blank_n), 32'd1);
    goto(0, 1);   check("bar_line1", rgb(), 32'hFFFFFF);
    mode = 2'd2;

    // Frame C: checkerboard, 32-pixel squares
    sync_frame("sync_chk");
    check("chk_0_0", rgb(), 32'h0);
    goto(31, 0);  check("chk_31_0", rgb(), 32'h0);
    goto(32, 0);  check("chk_32_0", rgb(), 32'hFFFFFF);
    goto(0, 32);  check("chk_0_32", rgb(), 32'hFFFFFF);
    goto(32, 32); check("chk_32_32", rgb(), 32'h0);
    mode = 2'd0;

    // Frame D: external pixels
    sync_frame("sync_ext");
    goto(40, 37); check("ext_40_37", rgb(), 32'h28255A);
    drop_en = 1'b1;

    // Frame E: one dropped pixel at (10,10)
    sync_frame("sync_drop");
    goto(9, 10);  check("ext_9_10", rgb(), 32'h090A5A);
                  check("under_pre", 32'(underrun), 32'd0);
    goto(10, 10); check("drop_black", rgb(), 32'h0);
                  check("drop_bn", 32'(vga_blank_n), 32'd1);
                  check("under_set", 32'(underrun), 32'd1);
    drop_en = 1'b0;
    goto(11, 10); check("ext_11_10", rgb(), 32'h0B0A5A);
    goto(20, 20); check("under_sticky", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    wait_cycle();
    underrun_clr = 1'b0;
    check("under_clr", 32'(underrun), 32'd0);

    // Request count over one full frame period, with a drop re-armed
    drop_en = 1'b1;
    reqs = 0;
    for (int i = 0; i < FRAME; i++) begin
      wait_cycle();
      if (req_valid) reqs++;
    end
    check("req_count", 32'(reqs), 32'(H_VIS * V_VIS));
    check("under_reset_again", 32'(underrun), 32'd1);
    drop_en = 1'b0;

    // en drop mid-frame
    en = 1'b0;
    wait_cycle();
    check("en0_blank", 32'(vga_blank_n), 32'd0);
    check("en0_hs", 32'(vga_hs), 32'd1);
    check("en0_vs", 32'(vga_vs), 32'd1);
    check("en0_rgb", rgb(), 32'h0);
    check("en0_req", 32'(req_valid), 32'd0);
    check("en0_under", 32'(underrun), 32'd1);
    repeat (5) wait_cycle();
    check("en0_fs", 32'(frame_start), 32'd0);
    en_rise_latency("en_lat1");
    goto(10, 5);  check("restart_10_5", rgb(), 32'h0A055A);

    // Async reset mid-line, no clock edge in between
    #2 rst_n = 1'b0;
    #1;
    check("arst_rgb", rgb(), 32'h0);
    check("arst_blank", 32'(vga_blank_n), 32'd0);
    check("arst_hs", 32'(vga_hs), 32'd1);
    check("arst_vs", 32'(vga_vs), 32'd1);
    check("arst_under", 32'(underrun), 32'd0);
    check("arst_req", 32'(req_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
